reg_writeback: RTL and testbench
================================

# reg_writeback

Writeback stage for the ucrv32 integer pipeline and the only writer of the register file's single write port. Arbitrates results from the single-cycle ALU path and the load/store unit onto the port, buffering ALU results when a load wins. Keeps a per-register pending (busy) scoreboard that the issue stage sets and writeback clears. Provides a same-cycle bypass so a read of a register being written this cycle returns the new value.

## Interface
- XLEN, 32: data width.
- NREG, 32: architectural registers; x0 hardwired zero.
- ALU_DEPTH, 2: ALU result FIFO entries (power of two, ≥2).

- clk  in  1  clock.
- n_rst  in  1  reset, asynchronous, active-low.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted when valid&&ready.
- alu_rd  in  5  ALU destination.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  load result; always accepted (no ready).
- lsu_rd  in  5  load destination.
- lsu_data  in  XLEN  load result.
- iss_valid  in  1  issue stage claims a destination.
- iss_rd  in  5  claimed destination.
- iss_ready  out  1  claim accepted when iss_valid&&iss_ready.
- rs1, rs2  in  5 each  operand indices from decode.
- busy_rs1, busy_rs2  out  1 each  operand pending and not bypassable.
- byp1_hit, byp2_hit  out  1 each  operand is being written this cycle.
- byp_data  out  XLEN  value to forward (equals rf_wd).
- rf_we  out  1  register-file write enable.
- rf_rd  out  5  register-file write index.
- rf_wd  out  XLEN  register-file write data.

## Operation
- Source select each cycle, priority order: (1) lsu_valid → LSU; (2) FIFO non-empty → pop head; (3) alu_valid with FIFO empty → ALU direct. Selected result loads output register (rf_we/rf_rd/rf_wd) at next edge; no selection → rf_we=0.
- ALU accepted but not selected → pushed into FIFO. alu_ready = !fifo_full (combinational, no push-while-full even if popping).
- FIFO preserves ALU order; ALU result never overtakes FIFO contents.
- rd=0 results: consumed normally, rf_we forced 0, no scoreboard effect.
- Scoreboard busy[NREG]: set at edge on iss_valid&&iss_ready&&iss_rd≠0; cleared at edge on rf_we for rf_rd. Different registers set and cleared same edge: both apply.
- iss_ready = (iss_rd==0) || !busy[iss_rd] (WAW stall; guarantees no same-register set/clear collision and makes LSU-over-ALU reordering safe).
- bypN_hit = rf_we && rf_rd==rsN && rsN≠0. busy_rsN = busy[rsN] && !bypN_hit && rsN≠0.
- Reset: busy all 0, FIFO empty, rf_we=0, rf_rd=0, rf_wd=0; alu_ready=1, iss_ready=1, hits 0. Reset mid-operation discards FIFO and output register contents.

## Timing
- LSU or direct ALU accepted cycle N → rf_we=1 cycle N+1, register file updated and busy cleared at end of N+1.
- ALU result buffered: written one cycle after the cycle it reaches head and is selected.
- Bypass visible combinationally during cycle N+1.
- LSU every cycle: ALU stalls after ALU_DEPTH accepted; FIFO drains at one per LSU-free cycle.
- Output register updates every cycle; rf_we deasserts the cycle after the last selection.

## Structure
- ucrv_pkg: XLEN, NREG, reg_idx_t (logic [4:0]), wb_src_e {WB_NONE, WB_LSU, WB_FIFO, WB_ALU}.
- One sub-module: wb_fifo (synchronous FIFO, parameter DEPTH/WIDTH, push/pop/full/empty, async active-low reset) holding {rd, data}.
- Top: select logic, output register, scoreboard, bypass compare.

## Test plan
- Reset mid-stream: FIFO holds 2 entries, n_rst pulsed low → rf_we=0, alu_ready=1, all busy 0, no stale write after release.
- Direct ALU: issue x5, alu_valid rd=5 data=0x1234 cycle N → rf_we=1 rf_rd=5 rf_wd=0x1234 cycle N+1, byp1_hit=1 for rs1=5, busy[5] clear cycle N+2.
- Collision: lsu rd=3 0xAAAA and alu rd=4 0xBBBB cycle N → x3 written N+1, x4 written N+2; alu_ready stays 1.
- Backpressure: lsu_valid every cycle for 4 cycles with alu_valid → 2 ALU accepted, alu_ready=0 next; after LSU stops, FIFO entries written in order on consecutive cycles.
- Scoreboard: claim x7, then iss_rd=7 again → iss_ready=0, busy_rs2=1 for rs2=7; after write clears, iss_ready=1. iss_rd=0 → iss_ready=1, no busy bit set.
- x0: alu rd=0 data=0xFFFF → alu_ready handshake completes, rf_we stays 0, byp hits 0 for rs1=0.

Source files
------------

// File: rtl/ucrv_pkg.sv
// rtl/ucrv_pkg.sv - shared widths, register index type and writeback source encoding
package ucrv_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_LSU  = 2'd1,
    WB_FIFO = 2'd2,
    WB_ALU  = 2'd3
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO buffering ALU results that lost arbitration
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - writeback arbitration, output register, pending scoreboard and bypass
module reg_writeback
  import ucrv_pkg::*;
#(
  parameter int XLEN      = ucrv_pkg::XLEN,
  parameter int NREG      = ucrv_pkg::NREG,
  parameter int ALU_DEPTH = 2
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  output logic            iss_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            busy_rs1,
  output logic            busy_rs2,
  output logic            byp1_hit,
  output logic            byp2_hit,
  output logic [XLEN-1:0] byp_data,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wd
);

  localparam int FW = 5 + XLEN;

  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic [FW-1:0]   fifo_head;
  logic            alu_fire;
  logic            iss_fire;
  wb_src_e         src;
  reg_idx_t        sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  assign alu_ready = !fifo_full;
  assign alu_fire  = alu_valid && alu_ready;

  // LSU always wins; buffered ALU results drain before a fresh one may go direct.
  always_comb begin
    src      = WB_NONE;
    sel_rd   = '0;
    sel_data = '0;
    if (lsu_valid) begin
      src      = WB_LSU;
      sel_rd   = lsu_rd;
      sel_data = lsu_data;
    end else if (!fifo_empty) begin
      src      = WB_FIFO;
      sel_rd   = fifo_head[FW-1:XLEN];
      sel_data = fifo_head[XLEN-1:0];
    end else if (alu_valid) begin
      src      = WB_ALU;
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end
  end

  assign fifo_pop  = (src == WB_FIFO);
  assign fifo_push = alu_fire && (src != WB_ALU);

  wb_fifo #(
    .DEPTH(ALU_DEPTH),
    .WIDTH(FW)
  ) u_fifo (
    .clk      (clk),
    .n_rst    (n_rst),
    .push     (fifo_push),
    .push_data({alu_rd, alu_data}),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= (src != WB_NONE) && (sel_rd != '0);
      rf_rd <= sel_rd;
      rf_wd <= sel_data;
    end
  end

  // WAW stall on a pending destination keeps set and clear of one register disjoint.
  assign iss_ready = (iss_rd == '0) || !busy[iss_rd];
  assign iss_fire  = iss_valid && iss_ready && (iss_rd != '0);

  always_comb begin
    busy_nxt = busy;
    if (rf_we)    busy_nxt[rf_rd]  = 1'b0;
    if (iss_fire) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign byp1_hit = rf_we && (rf_rd == rs1) && (rs1 != '0);
  assign byp2_hit = rf_we && (rf_rd == rs2) && (rs2 != '0);
  assign busy_rs1 = busy[rs1] && !byp1_hit && (rs1 != '0);
  assign busy_rs2 = busy[rs2] && !byp2_hit && (rs2 != '0);
  assign byp_data = rf_wd;

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - randomized scoreboard bench for reg_writeback
module tb_reg_writeback;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        alu_valid, alu_ready, lsu_valid, iss_valid, iss_ready;
  logic [4:0]  alu_rd, lsu_rd, iss_rd, rs1, rs2, rf_rd;
  logic [31:0] alu_data, lsu_data, byp_data, rf_wd;
  logic        busy_rs1, busy_rs2, byp1_hit, byp2_hit, rf_we;

  reg_writeback #(.XLEN(32), .NREG(32), .ALU_DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1(rs1), .rs2(rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
    .byp1_hit(byp1_hit), .byp2_hit(byp2_hit), .byp_data(byp_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t  pend_q[$];   // ALU results waiting behind the LSU
  wr_t  exp_q[$];    // register-file writes still to be observed
  logic mbusy[32];
  logic last_v;
  wr_t  last_w;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Every register-file write must be the next one the model predicted.
  always @(negedge clk) begin
    if (n_rst === 1'b1 && rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {59'd0, rf_rd}, 64'd0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_rd", {59'd0, rf_rd}, {59'd0, w.rd});
        chk("wr_data", {32'd0, rf_wd}, {32'd0, w.data});
      end
    end
  end

  task automatic model_clear();
    pend_q.delete();
    exp_q.delete();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    last_v = 1'b0;
  endtask

  // One cycle: drive, check combinational outputs, advance the model, cross the edge.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic iv, input logic [4:0] ird,
                      input logic [4:0] r1, input logic [4:0] r2);
    logic acc, ir, h1, h2, sel_v;
    wr_t  sel;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    iss_valid = iv; iss_rd = ird; rs1 = r1; rs2 = r2;
    #1;
    acc = pend_q.size() < DEPTH;
    ir  = (ird == 0) || !mbusy[ird];
    h1  = last_v && last_w.rd == r1 && r1 != 0;
    h2  = last_v && last_w.rd == r2 && r2 != 0;
    chk("alu_ready", {63'd0, alu_ready}, {63'd0, acc});
    chk("iss_ready", {63'd0, iss_ready}, {63'd0, ir});
    chk("byp1_hit", {63'd0, byp1_hit}, {63'd0, h1});
    chk("byp2_hit", {63'd0, byp2_hit}, {63'd0, h2});
    chk("busy_rs1", {63'd0, busy_rs1}, {63'd0, mbusy[r1] && !h1 && r1 != 0});
    chk("busy_rs2", {63'd0, busy_rs2}, {63'd0, mbusy[r2] && !h2 && r2 != 0});
    if (last_v) chk("byp_data", {32'd0, byp_data}, {32'd0, last_w.data});

    sel_v = 1'b1;
    sel.rd = 0; sel.data = 0;
    if (lv) begin
      sel.rd = lrd; sel.data = ld;
      if (av && acc) pend_q.push_back('{ard, ad});
    end else if (pend_q.size() > 0) begin
      sel = pend_q.pop_front();
      if (av && acc) pend_q.push_back('{ard, ad});
    end else if (av) begin
      sel.rd = ard; sel.data = ad;
    end else begin
      sel_v = 1'b0;
    end
    if (last_v) mbusy[last_w.rd] = 1'b0;
    if (iv && ir && ird != 0) mbusy[ird] = 1'b1;
    last_v = sel_v && sel.rd != 0;
    last_w = sel;
    if (last_v) exp_q.push_back(sel);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    alu_valid = 0; lsu_valid = 0; iss_valid = 0;
    alu_rd = 0; lsu_rd = 0; iss_rd = 9; alu_data = 0; lsu_data = 0;
    n_rst = 1'b0;
    model_clear();
    #1;
    chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
    chk("rst_rf_rd", {59'd0, rf_rd}, 64'd0);
    chk("rst_rf_wd", {32'd0, rf_wd}, 64'd0);
    chk("rst_alu_ready", {63'd0, alu_ready}, 64'd1);
    chk("rst_iss_ready", {63'd0, iss_ready}, 64'd1);
    for (int r = 0; r < 32; r++) begin
      rs1 = r[4:0]; rs2 = r[4:0];
      #1;
      chk("rst_busy", {62'd0, busy_rs1, busy_rs2}, 64'd0);
      chk("rst_hit", {62'd0, byp1_hit, byp2_hit}, 64'd0);
    end
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  initial begin
    n_rst = 1'b0;
    rs1 = 0; rs2 = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    do_reset();

    // direct ALU with bypass
    step(0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
    step(1, 5, 32'h1234, 0, 0, 0, 0, 0, 5, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5, 5);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5, 5);

    // LSU and ALU in the same cycle
    step(1, 4, 32'hBBBB, 1, 3, 32'hAAAA, 0, 0, 3, 4);
    idle(3);

    // sustained LSU backpressure
    for (int i = 0; i < 4; i++)
      step(1, 5'(10 + i), 32'hC000 + i, 1, 5'(20 + i), 32'hD000 + i, 0, 0, 0, 0);
    idle(4);

    // WAW stall and x0 claim
    step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 7, 0, 7);
    step(1, 7, 32'h77, 0, 0, 0, 1, 7, 0, 7);
    step(0, 0, 0, 0, 0, 0, 1, 7, 0, 7);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // x0 destination
    step(1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // reset with two entries buffered and a write in flight
    step(1, 11, 32'h11, 1, 12, 32'h12, 1, 13, 0, 0);
    step(1, 14, 32'h14, 1, 15, 32'h15, 1, 16, 0, 0);
    chk("fifo_full_before_reset", {63'd0, alu_ready}, 64'd0);
    do_reset();
    idle(4);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(6);
    chk("all_writes_seen", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
